// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu trace path: record layout and serializer FSM states.
package cpu_pkg;

    localparam int TRACE_W   = 12;
    localparam int PC_LSB    = 0;
    localparam int REG_LSB   = 3;
    localparam int ALU_LSB   = 7;
    localparam int CARRY_BIT = 11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } ser_state_t;

    function automatic logic [TRACE_W-1:0] pack_record(
        input logic [2:0] pc,
        input logic [3:0] rg,
        input logic [3:0] alu,
        input logic       carry
    );
        logic [TRACE_W-1:0] rec;
        rec                  = '0;
        rec[PC_LSB +: 3]     = pc;
        rec[REG_LSB +: 4]    = rg;
        rec[ALU_LSB +: 4]    = alu;
        rec[CARRY_BIT]       = carry;
        return rec;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO; a pop on the same edge frees a slot for a push into a full FIFO.
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/cpu_trace_serializer.sv
// Captures cpu observation outputs into 12-bit records and shifts them out as UART-style frames.
module cpu_trace_serializer
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic [2:0]             pc_in,
    input  logic [3:0]             reg_in,
    input  logic [3:0]             alu_in,
    input  logic                   carry_in,
    input  logic                   clr_overflow,
    output logic                   ser_out,
    output logic                   ser_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT = 4'(TRACE_W - 1);

    ser_state_t         state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [TRACE_W-1:0] shift_q, shift_d;
    logic               overflow_q, overflow_d;

    logic [TRACE_W-1:0] record;
    logic [TRACE_W-1:0] fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic               pop;
    logic               drop;
    logic               div_done;

    assign record   = pack_record(pc_in, reg_in, alu_in, carry_in);
    assign div_done = (div_cnt_q == DIV_LAST);

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_en),
        .pop   (pop),
        .wdata (record),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    // Popping on the STOP->START edge lets queued records go out with no idle gap.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (div_done) state_d = DATA;
            end
            DATA: begin
                if (div_done && (bit_cnt_q == LAST_BIT)) state_d = STOP;
            end
            STOP: begin
                if (div_done) begin
                    if (!fifo_empty) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_cnt_d = '0;
        if ((state_q != IDLE) && !div_done) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        bit_cnt_d = '0;
        if (state_q == DATA) begin
            bit_cnt_d = bit_cnt_q;
            if (div_done) begin
                bit_cnt_d = (bit_cnt_q == LAST_BIT) ? 4'd0 : bit_cnt_q + 4'd1;
            end
        end

        shift_d = shift_q;
        if (pop) begin
            shift_d = fifo_rdata;
        end else if ((state_q == DATA) && div_done) begin
            shift_d = {1'b0, shift_q[TRACE_W-1:1]};
        end

        // A drop on the same edge as a clear must leave the flag set.
        drop       = sample_en && fifo_full && !pop;
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            START:   ser_out = 1'b0;
            DATA:    ser_out = shift_q[0];
            default: ser_out = 1'b1;
        endcase
        ser_busy = (state_q != IDLE);
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Directed bench for cpu_trace_serializer: one fast instance (1 clk/bit) and one slow instance (3 clk/bit).
module tb_cpu_trace_serializer;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic       sample_en3;
    logic [2:0] pc_in;
    logic [3:0] reg_in;
    logic [3:0] alu_in;
    logic       carry_in;
    logic       clr_overflow;
    logic       ser_out, ser_busy, overflow;
    logic [2:0] fifo_count;
    logic       ser_out3, ser_busy3, overflow3;
    logic [2:0] fifo_count3;

    int checks;
    int passes;

    cpu_trace_serializer #(.DEPTH(4), .CLKS_PER_BIT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .pc_in        (pc_in),
        .reg_in       (reg_in),
        .alu_in       (alu_in),
        .carry_in     (carry_in),
        .clr_overflow (clr_overflow),
        .ser_out      (ser_out),
        .ser_busy     (ser_busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    cpu_trace_serializer #(.DEPTH(4), .CLKS_PER_BIT(3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en3),
        .pc_in        (pc_in),
        .reg_in       (reg_in),
        .alu_in       (alu_in),
        .carry_in     (carry_in),
        .clr_overflow (clr_overflow),
        .ser_out      (ser_out3),
        .ser_busy     (ser_busy3),
        .fifo_count   (fifo_count3),
        .overflow     (overflow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ser_busy || fifo_count != 3'd0) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (ser_busy !== 1'b0) $display("[TB] FAIL drain_timeout: busy=%b required 0", ser_busy);
        else passes++;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_en = 1'b0; sample_en3 = 1'b0; clr_overflow = 1'b0;
        pc_in = '0; reg_in = '0; alu_in = '0; carry_in = 1'b0;
        tick();
        tick();
        checks++; if (ser_out !== 1'b1) $display("[TB] FAIL reset_ser_out: got %b required 1", ser_out); else passes++;
        checks++; if (ser_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", ser_busy); else passes++;
        checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d required 0", fifo_count); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b required 0", overflow); else passes++;
        checks++; if (ser_out3 !== 1'b1) $display("[TB] FAIL reset_ser_out3: got %b required 1", ser_out3); else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [11:0] rec;
        logic        exp_ser, exp_busy;
        int          busy_cycles;
        rec = 12'h329;
        busy_cycles = 0;
        pc_in = 3'd1; reg_in = 4'b0101; alu_in = 4'b0110; carry_in = 1'b0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        checks++; if (fifo_count !== 3'd1) $display("[TB] FAIL single_count_push: got %0d required 1", fifo_count); else passes++;
        checks++; if (ser_busy !== 1'b0) $display("[TB] FAIL single_idle_before_pop: got %b required 0", ser_busy); else passes++;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_ser  = (k == 0) ? 1'b0 : (k <= 12) ? rec[k-1] : 1'b1;
            exp_busy = (k <= 13);
            if (ser_busy) busy_cycles++;
            checks++; if (ser_out !== exp_ser) $display("[TB] FAIL single_ser k=%0d: got %b required %b", k, ser_out, exp_ser); else passes++;
            checks++; if (ser_busy !== exp_busy) $display("[TB] FAIL single_busy k=%0d: got %b required %b", k, ser_busy, exp_busy); else passes++;
            if (k == 0) begin
                checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL single_count_pop: got %0d required 0", fifo_count); else passes++;
            end
        end
        checks++; if (busy_cycles != 14) $display("[TB] FAIL single_busy_len: got %0d required 14", busy_cycles); else passes++;
    endtask

    task automatic test_overflow_burst();
        logic        ser_log  [1:80];
        logic        busy_log [1:80];
        logic [11:0] got;
        int          busy_cycles;
        reg_in = '0; alu_in = '0; carry_in = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            sample_en = (i <= 6);
            pc_in     = 3'(i);
            tick();
            ser_log[i]  = ser_out;
            busy_log[i] = ser_busy;
            if (i == 5) begin
                checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL burst_full_count: got %0d required 4", fifo_count); else passes++;
                checks++; if (overflow !== 1'b0) $display("[TB] FAIL burst_no_overflow_yet: got %b required 0", overflow); else passes++;
            end
            if (i == 6) begin
                checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL burst_drop_count: got %0d required 4", fifo_count); else passes++;
                checks++; if (overflow !== 1'b1) $display("[TB] FAIL burst_overflow: got %b required 1", overflow); else passes++;
            end
        end
        sample_en = 1'b0;
        busy_cycles = 0;
        for (int i = 1; i <= 80; i++) if (busy_log[i]) busy_cycles++;
        checks++; if (busy_cycles != 70) $display("[TB] FAIL burst_busy_total: got %0d required 70", busy_cycles); else passes++;
        checks++; if (busy_log[1] !== 1'b0) $display("[TB] FAIL burst_pop_edge: busy after edge1 got %b required 0", busy_log[1]); else passes++;
        checks++; if (busy_log[72] !== 1'b0) $display("[TB] FAIL burst_end: busy after edge72 got %b required 0", busy_log[72]); else passes++;
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < 12; j++) got[j] = ser_log[3 + 14*f + j];
            checks++; if (ser_log[2 + 14*f] !== 1'b0) $display("[TB] FAIL burst_start f=%0d: got %b required 0", f, ser_log[2 + 14*f]); else passes++;
            checks++; if (got !== 12'(f + 1)) $display("[TB] FAIL burst_record f=%0d: got %h required %h", f, got, 12'(f + 1)); else passes++;
            checks++; if (ser_log[15 + 14*f] !== 1'b1) $display("[TB] FAIL burst_stop f=%0d: got %b required 1", f, ser_log[15 + 14*f]); else passes++;
        end
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL burst_sticky: got %b required 1", overflow); else passes++;
    endtask

    task automatic test_clear_overflow();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL clear_overflow: got %b required 0", overflow); else passes++;
    endtask

    task automatic test_clear_vs_drop();
        for (int i = 1; i <= 7; i++) begin
            sample_en    = 1'b1;
            clr_overflow = (i == 7);
            pc_in        = 3'(i);
            tick();
            if (i == 6) begin
                checks++; if (overflow !== 1'b1) $display("[TB] FAIL cvd_set: got %b required 1", overflow); else passes++;
            end
        end
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL cvd_set_wins: got %b required 1", overflow); else passes++;
        checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL cvd_count: got %0d required 4", fifo_count); else passes++;
        sample_en    = 1'b0;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL cvd_clear_after: got %b required 0", overflow); else passes++;
        drain();
    endtask

    task automatic test_pop_edge_push();
        for (int i = 1; i <= 16; i++) begin
            sample_en = (i <= 5) || (i == 16);
            pc_in     = 3'(i);
            tick();
            if (i == 15) begin
                checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL popedge_pre_count: got %0d required 4", fifo_count); else passes++;
                checks++; if (ser_out !== 1'b1) $display("[TB] FAIL popedge_stop_bit: got %b required 1", ser_out); else passes++;
            end
        end
        sample_en = 1'b0;
        checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL popedge_count: got %0d required 4", fifo_count); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL popedge_overflow: got %b required 0", overflow); else passes++;
        checks++; if (ser_out !== 1'b0) $display("[TB] FAIL popedge_next_start: got %b required 0", ser_out); else passes++;
        drain();
    endtask

    task automatic test_reset_mid_frame();
        int violations;
        pc_in = 3'd1; reg_in = 4'b0101; alu_in = 4'b0110; carry_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            sample_en = (i <= 3);
            tick();
        end
        checks++; if (fifo_count !== 3'd2) $display("[TB] FAIL midrst_pre_count: got %0d required 2", fifo_count); else passes++;
        checks++; if (ser_busy !== 1'b1) $display("[TB] FAIL midrst_pre_busy: got %b required 1", ser_busy); else passes++;
        checks++; if (ser_out !== 1'b1) $display("[TB] FAIL midrst_bit5: got %b required 1", ser_out); else passes++;
        rst       = 1'b1;
        sample_en = 1'b1;
        tick();
        rst       = 1'b0;
        sample_en = 1'b0;
        checks++; if (ser_out !== 1'b1) $display("[TB] FAIL midrst_ser_out: got %b required 1", ser_out); else passes++;
        checks++; if (ser_busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b required 0", ser_busy); else passes++;
        checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL midrst_count: got %0d required 0", fifo_count); else passes++;
        violations = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ser_busy !== 1'b0 || ser_out !== 1'b1) violations++;
        end
        checks++; if (violations != 0) $display("[TB] FAIL midrst_no_tail: got %0d active cycles required 0", violations); else passes++;
    endtask

    task automatic test_slow_frame();
        logic exp_ser, exp_busy;
        int   busy_cycles;
        busy_cycles = 0;
        pc_in = 3'd7; reg_in = 4'hF; alu_in = 4'hF; carry_in = 1'b1;
        sample_en3 = 1'b1;
        tick();
        sample_en3 = 1'b0;
        checks++; if (fifo_count3 !== 3'd1) $display("[TB] FAIL slow_count_push: got %0d required 1", fifo_count3); else passes++;
        for (int k = 0; k < 45; k++) begin
            tick();
            exp_ser  = (k >= 3);
            exp_busy = (k < 42);
            if (ser_busy3) busy_cycles++;
            checks++; if (ser_out3 !== exp_ser) $display("[TB] FAIL slow_ser k=%0d: got %b required %b", k, ser_out3, exp_ser); else passes++;
            checks++; if (ser_busy3 !== exp_busy) $display("[TB] FAIL slow_busy k=%0d: got %b required %b", k, ser_busy3, exp_busy); else passes++;
        end
        checks++; if (busy_cycles != 42) $display("[TB] FAIL slow_frame_len: got %0d required 42", busy_cycles); else passes++;
        checks++; if (overflow3 !== 1'b0) $display("[TB] FAIL slow_overflow: got %b required 0", overflow3); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_single_frame();
        test_overflow_burst();
        test_clear_overflow();
        test_clear_vs_drop();
        test_pop_edge_push();
        test_reset_mid_frame();
        test_slow_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
